// File: rtl/if_id_stage.sv
// Fetch-side stage: next-PC selection for ProgramCounter, the IF/ID pipeline
// register with stall/flush control, and a retired-fetch counter.
module if_id_stage #(
    parameter logic [31:0] ADDR_LIMIT = 32'd127,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic [31:0]      Instruction,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    output logic [31:0]      Address,
    output logic [31:0]      IF_ID_Instruction,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] FetchCount
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [31:0]      pcPlus4;
    logic [31:0]      selectedAddr;
    logic             redirect;
    logic             loadSlot;

    logic [31:0]      instrQ, instrD;
    logic [31:0]      pcPlus4Q, pcPlus4D;
    logic             validQ, validD;
    logic [CNT_W-1:0] countQ, countD;

    assign pcPlus4  = PC + 32'd4;
    assign redirect = Jump || BranchTaken;
    assign loadSlot = !(Flush || redirect) && !Stall;

    // Redirect targets are word-aligned before use; anything beyond the
    // instruction memory range collapses to address 0.
    always_comb begin
        selectedAddr = pcPlus4;
        if (Jump) begin
            selectedAddr = JumpTarget & ~32'h3;
        end else if (BranchTaken) begin
            selectedAddr = BranchTarget & ~32'h3;
        end else if (Stall) begin
            selectedAddr = PC;
        end
        Address = selectedAddr;
        if (!Reset || (selectedAddr > ADDR_LIMIT)) begin
            Address = 32'd0;
        end
    end

    always_comb begin
        instrD   = instrQ;
        pcPlus4D = pcPlus4Q;
        validD   = validQ;
        countD   = countQ;
        if (Flush || redirect) begin
            instrD   = NOP_WORD;
            pcPlus4D = 32'd0;
            validD   = 1'b0;
        end else if (loadSlot) begin
            instrD   = Instruction;
            pcPlus4D = pcPlus4;
            validD   = 1'b1;
            countD   = countQ + CntOne;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instrQ   <= NOP_WORD;
            pcPlus4Q <= 32'd0;
            validQ   <= 1'b0;
            countQ   <= '0;
        end else begin
            instrQ   <= instrD;
            pcPlus4Q <= pcPlus4D;
            validQ   <= validD;
            countQ   <= countD;
        end
    end

    assign IF_ID_Instruction = instrQ;
    assign IF_ID_PCPlus4     = pcPlus4Q;
    assign IF_ID_Valid       = validQ;
    assign FetchCount        = countQ;

endmodule
